// File: rtl/sym_hist_pkg.sv
// Shared types and helpers for the symbol histogram bank.
package sym_hist_pkg;

  localparam int MAX_NSYM = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FLUSH = 2'd2,
    READY = 2'd3
  } hist_state_t;

  // Flag field of entry idx: a common top marker plus a one-hot tag in reverse channel order.
  function automatic logic [MAX_NSYM:0] init_flag(input int nsym, input int idx);
    logic [MAX_NSYM:0] one;
    one = {{MAX_NSYM{1'b0}}, 1'b1};
    return (one << nsym) | (one << (nsym - 1 - idx));
  endfunction

endpackage

// File: rtl/sym_hist_if.sv
// Symbol stream plus entry load/read bus of the histogram bank.
interface sym_hist_if #(
  parameter int NSYM = 6,
  parameter int CW   = 8,
  parameter int SW   = 8
);
  localparam int FW = NSYM + 1;
  localparam int EW = CW + FW;
  localparam int IW = $clog2(NSYM);

  logic          sym_valid;
  logic [SW-1:0] sym;
  logic          sym_last;
  logic          ld_en;
  logic [IW-1:0] ld_idx;
  logic [EW-1:0] ld_data;
  logic [IW-1:0] rd_idx;
  logic [EW-1:0] rd_data;

  modport master (
    output sym_valid, sym, sym_last, ld_en, ld_idx, ld_data, rd_idx,
    input  rd_data
  );

  modport slave (
    input  sym_valid, sym, sym_last, ld_en, ld_idx, ld_data, rd_idx,
    output rd_data
  );
endinterface

// File: rtl/sym_hist_cell.sv
// One histogram entry: {count, flag} with init value, saturating count and whole-entry load.
module sym_hist_cell
  import sym_hist_pkg::*;
#(
  parameter int NSYM = 6,
  parameter int CW   = 8,
  parameter int IDX  = 0,
  localparam int FW  = NSYM + 1,
  localparam int EW  = CW + FW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic          ld,
  input  logic [EW-1:0] ld_data,
  output logic [EW-1:0] entry,
  output logic          sat_hit
);
  localparam logic [FW-1:0] INIT_FLAG = FW'(init_flag(NSYM, IDX));

  logic [CW-1:0] count;
  logic [FW-1:0] flag;

  // Increments only ever touch the count; the flag changes solely through init or load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      flag  <= INIT_FLAG;
    end else if (clear) begin
      count <= '0;
      flag  <= INIT_FLAG;
    end else if (ld) begin
      count <= ld_data[EW-1:FW];
      flag  <= ld_data[FW-1:0];
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign sat_hit = inc && !ld && (count == '1);
  assign entry   = {count, flag};
endmodule

// File: rtl/sym_hist_bank.sv
// Histogram of a symbol stream over NSYM channels, with a one-stage commit pipeline.
module sym_hist_bank
  import sym_hist_pkg::*;
#(
  parameter int NSYM = 6,
  parameter int CW   = 8,
  parameter int SW   = 8,
  localparam int FW  = NSYM + 1,
  localparam int EW  = CW + FW,
  localparam int IW  = $clog2(NSYM),
  localparam int TW  = CW + IW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start,
  sym_hist_if.slave          bus,
  output logic [NSYM*EW-1:0] entries,
  output logic [TW-1:0]      total,
  output logic [CW-1:0]      miss,
  output logic               sat,
  output logic               ready,
  output logic               done
);
  hist_state_t     state;
  hist_state_t     state_next;
  logic            accept;
  logic            ld_ok;
  logic            pipe_valid;
  logic [SW-1:0]   pipe_sym;
  logic            pipe_in_range;
  logic [IW-1:0]   pipe_chan;
  logic [NSYM-1:0] cell_inc;
  logic [NSYM-1:0] cell_ld;
  logic [NSYM-1:0] cell_sat;
  logic [EW-1:0]   entry_arr [NSYM];
  logic            total_sat_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == FLUSH) && (state_next == READY);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COUNT;
      COUNT:   if (accept && bus.sym_last) state_next = FLUSH;
      FLUSH:   state_next = READY;
      READY:   state_next = READY;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_comb begin
    ready  = (state == READY);
    accept = (state == COUNT) && bus.sym_valid;
    ld_ok  = (state == READY) && bus.ld_en && (int'(bus.ld_idx) < NSYM);
  end

  // The stage drains whatever the state, so the final symbol commits during FLUSH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid <= 1'b0;
      pipe_sym   <= '0;
    end else if (clear) begin
      pipe_valid <= 1'b0;
      pipe_sym   <= '0;
    end else begin
      pipe_valid <= accept;
      if (accept) pipe_sym <= bus.sym;
    end
  end

  assign pipe_in_range = pipe_valid && (pipe_sym != '0) && (int'(pipe_sym) <= NSYM);
  assign pipe_chan     = IW'(pipe_sym - 1'b1);

  for (genvar i = 0; i < NSYM; i++) begin : g_cell
    assign cell_inc[i] = pipe_in_range && (pipe_chan == IW'(i));
    assign cell_ld[i]  = ld_ok && (bus.ld_idx == IW'(i));

    sym_hist_cell #(
      .NSYM (NSYM),
      .CW   (CW),
      .IDX  (i)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .inc     (cell_inc[i]),
      .ld      (cell_ld[i]),
      .ld_data (bus.ld_data),
      .entry   (entry_arr[i]),
      .sat_hit (cell_sat[i])
    );

    assign entries[i*EW +: EW] = entry_arr[i];
  end

  assign total_sat_hit = pipe_in_range && (total == '1);

  // Out-of-range symbols saturate miss silently; only entry or total overflow raises sat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total <= '0;
      miss  <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      total <= '0;
      miss  <= '0;
      sat   <= 1'b0;
    end else begin
      if (pipe_in_range && (total != '1)) total <= total + 1'b1;
      if (pipe_valid && !pipe_in_range && (miss != '1)) miss <= miss + 1'b1;
      if (total_sat_hit || (|cell_sat)) sat <= 1'b1;
    end
  end

  assign bus.rd_data = (int'(bus.rd_idx) < NSYM) ? entry_arr[bus.rd_idx] : '0;
endmodule

// File: tb/tb_sym_hist_bank.sv
// Two banks (CW=8 and CW=4) fed the same stimulus and compared against a per-pass symbol tally.
module tb_sym_hist_bank;
  localparam int NSYM = 6;
  localparam int SW   = 8;
  localparam int CW_A = 8;
  localparam int CW_B = 4;
  localparam int IW   = $clog2(NSYM);
  localparam int EW_A = CW_A + NSYM + 1;
  localparam int EW_B = CW_B + NSYM + 1;
  localparam int TW_A = CW_A + IW;
  localparam int TW_B = CW_B + IW;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic start;

  sym_hist_if #(.NSYM(NSYM), .CW(CW_A), .SW(SW)) ifa ();
  sym_hist_if #(.NSYM(NSYM), .CW(CW_B), .SW(SW)) ifb ();

  logic [NSYM*EW_A-1:0] entries_a;
  logic [TW_A-1:0]      total_a;
  logic [CW_A-1:0]      miss_a;
  logic                 sat_a, ready_a, done_a;
  logic [NSYM*EW_B-1:0] entries_b;
  logic [TW_B-1:0]      total_b;
  logic [CW_B-1:0]      miss_b;
  logic                 sat_b, ready_b, done_b;

  assign ifb.sym_valid = ifa.sym_valid;
  assign ifb.sym       = ifa.sym;
  assign ifb.sym_last  = ifa.sym_last;
  assign ifb.ld_en     = ifa.ld_en;
  assign ifb.ld_idx    = ifa.ld_idx;
  assign ifb.ld_data   = ifa.ld_data[EW_B-1:0];
  assign ifb.rd_idx    = ifa.rd_idx;

  sym_hist_bank #(.NSYM(NSYM), .CW(CW_A), .SW(SW)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .bus(ifa),
    .entries(entries_a), .total(total_a), .miss(miss_a),
    .sat(sat_a), .ready(ready_a), .done(done_a)
  );

  sym_hist_bank #(.NSYM(NSYM), .CW(CW_B), .SW(SW)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .bus(ifb),
    .entries(entries_b), .total(total_b), .miss(miss_b),
    .sat(sat_b), .ready(ready_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int raw_cnt [NSYM];
  int raw_total;
  int raw_miss;
  bit loaded [NSYM];
  logic [EW_A-1:0] load_val [NSYM];
  int num_compared = 0;
  int num_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int clip(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int flagOf(input int i);
    return (1 << NSYM) | (1 << (NSYM - 1 - i));
  endfunction

  function automatic logic [31:0] expEntry(input int i, input int cw);
    if (loaded[i]) return (cw == CW_A) ? 32'(load_val[i]) : 32'(load_val[i][EW_B-1:0]);
    return 32'((clip(raw_cnt[i], (1 << cw) - 1) << (NSYM + 1)) | flagOf(i));
  endfunction

  function automatic logic [31:0] expSat(input int cw);
    bit s;
    s = raw_total > ((1 << (cw + IW)) - 1);
    for (int i = 0; i < NSYM; i++) if (raw_cnt[i] > (1 << cw) - 1) s = 1'b1;
    return 32'(s);
  endfunction

  function automatic int randSym(input int oor_pct);
    if (int'($urandom_range(0, 99)) < oor_pct)
      return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(NSYM + 1, 255));
    return int'($urandom_range(1, NSYM));
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < NSYM; i++) begin
      raw_cnt[i]  = 0;
      loaded[i]   = 1'b0;
      load_val[i] = '0;
    end
    raw_total = 0;
    raw_miss  = 0;
  endfunction

  function automatic void noteSymbol(input int s);
    if (s >= 1 && s <= NSYM) begin
      raw_cnt[s-1]++;
      raw_total++;
    end else begin
      raw_miss++;
    end
  endfunction

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic verifyBank(input string where, input bit exp_ready);
    for (int i = 0; i < NSYM; i++) begin
      checkOutput($sformatf("%s a.entry%0d", where, i), 32'(entries_a[i*EW_A +: EW_A]), expEntry(i, CW_A));
      checkOutput($sformatf("%s b.entry%0d", where, i), 32'(entries_b[i*EW_B +: EW_B]), expEntry(i, CW_B));
    end
    checkOutput({where, " a.total"}, 32'(total_a), 32'(clip(raw_total, (1 << TW_A) - 1)));
    checkOutput({where, " b.total"}, 32'(total_b), 32'(clip(raw_total, (1 << TW_B) - 1)));
    checkOutput({where, " a.miss"}, 32'(miss_a), 32'(clip(raw_miss, (1 << CW_A) - 1)));
    checkOutput({where, " b.miss"}, 32'(miss_b), 32'(clip(raw_miss, (1 << CW_B) - 1)));
    checkOutput({where, " a.sat"}, 32'(sat_a), expSat(CW_A));
    checkOutput({where, " b.sat"}, 32'(sat_b), expSat(CW_B));
    checkOutput({where, " a.ready"}, 32'(ready_a), 32'(exp_ready));
    checkOutput({where, " b.ready"}, 32'(ready_b), 32'(exp_ready));
  endtask

  task automatic readCheck(input int idx);
    ifa.rd_idx = IW'(idx);
    #1;
    checkOutput($sformatf("rd a.idx%0d", idx), 32'(ifa.rd_data), (idx < NSYM) ? expEntry(idx, CW_A) : 32'h0);
    checkOutput($sformatf("rd b.idx%0d", idx), 32'(ifb.rd_data), (idx < NSYM) ? expEntry(idx, CW_B) : 32'h0);
  endtask

  // One full pass: start, symbols with random idle gaps carrying ignored start/ld_en, then done timing.
  task automatic applyStimulus(input int syms[$]);
    int n;
    n = syms.size();
    ifa.sym_valid = 1'b1;
    ifa.sym       = 8'd1;
    ifa.sym_last  = 1'b0;
    start = 1'b1;
    stepClock();
    start = 1'b0;
    ifa.sym_valid = 1'b0;
    checkOutput("pass ready_in_count", 32'(ready_a), 32'h0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        ifa.sym_valid = 1'b0;
        ifa.sym       = 8'($urandom);
        ifa.sym_last  = 1'($urandom);
        start         = 1'($urandom);
        ifa.ld_en     = 1'b1;
        ifa.ld_idx    = IW'($urandom_range(0, NSYM - 1));
        ifa.ld_data   = EW_A'($urandom);
        stepClock();
      end
      start         = 1'b0;
      ifa.ld_en     = 1'b0;
      ifa.sym_valid = 1'b1;
      ifa.sym       = 8'(syms[i]);
      ifa.sym_last  = (i == n - 1);
      noteSymbol(syms[i]);
      stepClock();
    end
    ifa.sym = 8'($urandom_range(1, NSYM));
    checkOutput("pass done_in_flush", 32'(done_a), 32'h0);
    stepClock();
    ifa.sym_valid = 1'b0;
    ifa.sym_last  = 1'b0;
    checkOutput("pass a.done_pulse", 32'(done_a), 32'h1);
    checkOutput("pass b.done_pulse", 32'(done_b), 32'h1);
    checkOutput("pass b.ready", 32'(ready_b), 32'h1);
    stepClock();
    checkOutput("pass a.done_drop", 32'(done_a), 32'h0);
  endtask

  task automatic loadOne(input int idx, input logic [EW_A-1:0] data);
    ifa.ld_en     = 1'b1;
    ifa.ld_idx    = IW'(idx);
    ifa.ld_data   = data;
    start         = 1'($urandom);
    ifa.sym_valid = 1'($urandom);
    ifa.sym       = 8'($urandom_range(1, NSYM));
    ifa.sym_last  = 1'($urandom);
    stepClock();
    if (idx < NSYM) begin
      loaded[idx]   = 1'b1;
      load_val[idx] = data;
    end
    ifa.ld_en     = 1'b0;
    start         = 1'b0;
    ifa.sym_valid = 1'b0;
    ifa.sym_last  = 1'b0;
  endtask

  task automatic applyClear();
    clear = 1'b1;
    stepClock();
    clear = 1'b0;
    clearModel();
    checkOutput("clear a.done", 32'(done_a), 32'h0);
    verifyBank("clear", 1'b0);
  endtask

  task automatic applyResetMidPass();
    start = 1'b1;
    stepClock();
    start = 1'b0;
    repeat ($urandom_range(2, 8)) begin
      ifa.sym_valid = 1'b1;
      ifa.sym       = 8'(randSym(20));
      ifa.sym_last  = 1'b0;
      stepClock();
    end
    #2 reset = 1'b0;
    #1;
    clearModel();
    checkOutput("async_reset a.done", 32'(done_a), 32'h0);
    verifyBank("async_reset", 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) stepClock();
    ifa.sym_valid = 1'b0;
    stepClock();
    verifyBank("after_reset_no_start", 1'b0);
  endtask

  initial begin
    int q[$];
    int n;
    int oor;
    reset = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    ifa.sym_valid = 1'b0;
    ifa.sym       = '0;
    ifa.sym_last  = 1'b0;
    ifa.ld_en     = 1'b0;
    ifa.ld_idx    = '0;
    ifa.ld_data   = '0;
    ifa.rd_idx    = '0;
    clearModel();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    stepClock();

    $display("[TB] reset state");
    checkOutput("reset a.entry0", 32'(entries_a[0 +: EW_A]), 32'h0060);
    checkOutput("reset a.entry5", 32'(entries_a[5*EW_A +: EW_A]), 32'h0041);
    checkOutput("reset a.total", 32'(total_a), 32'h0);
    checkOutput("reset a.ready", 32'(ready_a), 32'h0);
    verifyBank("reset", 1'b0);

    $display("[TB] basic pass and loads");
    q.delete();
    q.push_back(1); q.push_back(1); q.push_back(3);
    q.push_back(6); q.push_back(6); q.push_back(6);
    applyStimulus(q);
    checkOutput("basic a.entry0", 32'(entries_a[0 +: EW_A]), 32'h0160);
    checkOutput("basic a.entry2", 32'(entries_a[2*EW_A +: EW_A]), 32'h00C8);
    checkOutput("basic a.entry5", 32'(entries_a[5*EW_A +: EW_A]), 32'h01C1);
    checkOutput("basic a.total", 32'(total_a), 32'd6);
    verifyBank("basic", 1'b1);
    loadOne(2, 15'h7F80);
    loadOne(7, 15'h1234);
    checkOutput("load a.entry2", 32'(entries_a[2*EW_A +: EW_A]), 32'h7F80);
    checkOutput("load b.entry2", 32'(entries_b[2*EW_B +: EW_B]), 32'h0780);
    verifyBank("load", 1'b1);
    readCheck(2);
    readCheck(7);
    readCheck(5);
    applyClear();

    $display("[TB] out-of-range symbols");
    q.delete();
    q.push_back(0); q.push_back(7); q.push_back(255);
    applyStimulus(q);
    checkOutput("oor a.miss", 32'(miss_a), 32'd3);
    checkOutput("oor a.total", 32'(total_a), 32'd0);
    verifyBank("oor", 1'b1);
    applyClear();
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(randSym(100));
    applyStimulus(q);
    checkOutput("miss_sat b.miss", 32'(miss_b), 32'd15);
    checkOutput("miss_sat b.sat", 32'(sat_b), 32'd0);
    verifyBank("miss_sat", 1'b1);
    applyClear();

    $display("[TB] count and total saturation");
    q.delete();
    for (int i = 0; i < 17; i++) q.push_back(2);
    applyStimulus(q);
    checkOutput("cnt_sat b.entry1", 32'(entries_b[1*EW_B +: EW_B]), 32'h07D0);
    checkOutput("cnt_sat b.sat", 32'(sat_b), 32'h1);
    checkOutput("cnt_sat b.total", 32'(total_b), 32'd17);
    checkOutput("cnt_sat a.sat", 32'(sat_a), 32'h0);
    verifyBank("cnt_sat", 1'b1);
    applyClear();
    q.delete();
    for (int i = 0; i < 140; i++) q.push_back(randSym(0));
    applyStimulus(q);
    checkOutput("tot_sat b.total", 32'(total_b), 32'd127);
    checkOutput("tot_sat b.sat", 32'(sat_b), 32'h1);
    checkOutput("tot_sat a.total", 32'(total_a), 32'd140);
    verifyBank("tot_sat", 1'b1);
    applyClear();

    $display("[TB] load during COUNT");
    start = 1'b1;
    stepClock();
    start = 1'b0;
    ifa.ld_en   = 1'b1;
    ifa.ld_idx  = IW'(2);
    ifa.ld_data = 15'h7F80;
    stepClock();
    ifa.ld_en = 1'b0;
    checkOutput("ld_count a.entry2", 32'(entries_a[2*EW_A +: EW_A]), 32'h0048);
    ifa.sym_valid = 1'b1;
    ifa.sym       = 8'd2;
    ifa.sym_last  = 1'b1;
    noteSymbol(2);
    stepClock();
    ifa.sym_valid = 1'b0;
    ifa.sym_last  = 1'b0;
    repeat (2) stepClock();
    verifyBank("ld_count", 1'b1);
    applyClear();

    $display("[TB] clear racing sym_last and start");
    start = 1'b1;
    stepClock();
    start = 1'b0;
    ifa.sym_valid = 1'b1;
    ifa.sym = 8'd3;
    stepClock();
    ifa.sym = 8'd4;
    stepClock();
    ifa.sym      = 8'd5;
    ifa.sym_last = 1'b1;
    clear        = 1'b1;
    start        = 1'b1;
    stepClock();
    clear = 1'b0;
    start = 1'b0;
    ifa.sym_last = 1'b0;
    ifa.sym = 8'd1;
    clearModel();
    verifyBank("clear_race", 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ifa.sym_valid = 1'b0;
      checkOutput($sformatf("clear_race a.done c%0d", i), 32'(done_a), 32'h0);
      checkOutput($sformatf("clear_race b.done c%0d", i), 32'(done_b), 32'h0);
      stepClock();
    end
    verifyBank("clear_race_idle", 1'b0);

    $display("[TB] reset mid-pass");
    applyResetMidPass();

    $display("[TB] randomized passes");
    for (int it = 0; it < 30; it++) begin
      q.delete();
      n   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(130, 150)) : int'($urandom_range(1, 30));
      oor = int'($urandom_range(0, 30));
      for (int i = 0; i < n; i++) q.push_back(randSym(oor));
      applyStimulus(q);
      verifyBank($sformatf("rand%0d", it), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) loadOne(int'($urandom_range(0, 7)), EW_A'($urandom));
        verifyBank($sformatf("rand%0d load", it), 1'b1);
        readCheck(int'($urandom_range(0, 7)));
      end
      applyClear();
      if ($urandom_range(0, 5) == 0) applyResetMidPass();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end
endmodule
